alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one combinational 8-bit ALU (mult/or/and/logical-and, 2-bit op select) between NREQ requesters.
//  Round-robin arbitration, valid/ready request and response channels, multi-cycle hold for multiply.
//  Sits in front of the ALU and replaces free-running counter-based op selection with demand-driven sequencing.
// PARAMETERS
//  NREQ        4  number of requesters (2..16)
//  WIDTH       8  operand/result width; must match the ALU
//  MULT_CYCLES 2  cycles operands are held for op 0 (multiply), >=1
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   NREQ         request valid, one bit per requester
//  req_ready  out  NREQ         one-hot grant/accept
//  req_op     in   2*NREQ       op per requester: 0 mult, 1 or, 2 and, 3 logical-and
//  req_a      in   WIDTH*NREQ   operand A per requester (requester i at [i*WIDTH +: WIDTH])
//  req_b      in   WIDTH*NREQ   operand B per requester
//  alu_sel    out  2            op select to ALU mux
//  alu_a      out  WIDTH        operand A to ALU
//  alu_b      out  WIDTH        operand B to ALU
//  alu_result in   WIDTH        ALU result (combinational from alu_sel/alu_a/alu_b)
//  rsp_valid  out  1            response valid
//  rsp_ready  in   1            response consumer ready
//  rsp_id     out  $clog2(NREQ) index of the requester that issued the op
//  rsp_data   out  WIDTH        captured result
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; rr_ptr=NREQ-1 (req 0 has top priority first); alu_sel/alu_a/alu_b=0;
//   rsp_valid=0; rsp_id=0; rsp_data=0; req_ready=0. Reset mid-op drops the op; no response is produced.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: req_ready is combinational, one-hot on winner g = first i with req_valid[i], scanning rr_ptr+1..rr_ptr
//   modulo NREQ (wrap). All-zero when no valid. Handshake on that edge: latch op/a/b into alu_* regs,
//   rsp_id<=g, rr_ptr<=g, hold_cnt<=(op==0 ? MULT_CYCLES-1 : 0), go EXEC.
//  EXEC: alu_* stable. hold_cnt decrements each cycle; at hold_cnt==0: rsp_data<=alu_result, go RESP.
//  RESP: rsp_valid=1; rsp_id/rsp_data stable until rsp_ready=1, then IDLE.
//   req_ready=0 in EXEC and RESP. No new grant in the same cycle a response completes.
//  Latency: accept at cycle T -> rsp_valid at T+1+L, where L=MULT_CYCLES for op 0 and 1 otherwise.
//   Min issue interval is 3 cycles.
//  Requester that drops req_valid before grant is never granted; valid stays high until ready.
//  Width: rsp_data is the ALU's WIDTH-bit result unchanged (multiply truncated by ALU; logical-and is 0/1).
//  Ops not 0..3 cannot occur (2-bit field). alu_* keep last values after IDLE (no return to 0).
// CONFIGURATION
//  ALU_OP_STATS_EN defined: extra output stat_cnt[63:0], four 16-bit counters [16*op +: 16], +1 on each accepted op
//   of that type, saturating at 16'hFFFF, cleared by reset only.
//  Undefined: port and counters absent; all other behaviour identical.
// TESTING
//  Single req: req1 op 1 a=8'h0F b=8'hF0 at T -> req_ready=4'b0010 at T; rsp_valid at T+2, rsp_id=1, rsp_data=8'hFF.
//  Multiply: req0 op 0 a=8'd20 b=8'd13, MULT_CYCLES=2 -> rsp_valid at T+3, rsp_data=8'h04 (260 mod 256).
//  Fairness: all 4 reqs held valid from reset -> grant order 0,1,2,3,0; each granted exactly once per 4 ops.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_id/rsp_data held; req_ready=0 throughout; then IDLE.
//  Reset mid-EXEC: rst_n low during EXEC of req2 -> outputs at reset values immediately; no rsp for req2; next
//   grant starts from req0.
//  With ALU_OP_STATS_EN: 3 logical-and ops (a=5,b=0 -> 0; a=5,b=1 -> 1; a=0,b=0 -> 0) -> stat_cnt[63:48]=3,
//   others 0; force 65536 ops -> stays 16'hFFFF.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one external combinational ALU (0 mult, 1 or, 2 and, 3 logical-and)
//   between NREQ requesters. A round-robin arbiter accepts one request at a
//   time, holds the operands on the ALU for the op's latency, captures the
//   result and presents it on a valid/ready response channel.
//
//   Sequencing: IDLE (grant) -> EXEC (operands held) -> RESP (wait consumer).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready is one-hot)
//   req_op/a/b          packed per-requester op and operands
//   alu_sel/a/b         registered drive to the ALU
//   alu_result          ALU result, combinational from alu_sel/a/b
//   rsp_valid/ready     response handshake
//   rsp_id, rsp_data    issuing requester and captured result
//   stat_cnt            (only with ALU_OP_STATS_EN) four saturating 16-bit
//                       accepted-op counters, counter for op k at [16*k +: 16]
//
// Configuration macro: ALU_OP_STATS_EN
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int MULT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [2*NREQ-1:0]         req_op,
    input  logic [WIDTH*NREQ-1:0]     req_a,
    input  logic [WIDTH*NREQ-1:0]     req_b,
    output logic [1:0]                alu_sel,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    input  logic [WIDTH-1:0]          alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_data
`ifdef ALU_OP_STATS_EN
    ,
    output logic [63:0]               stat_cnt
`endif
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [CNTW-1:0]  hold_q,     hold_d;
    logic [1:0]       alu_sel_q,  alu_sel_d;
    logic [WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [IDW-1:0]   rsp_id_q,   rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             found;
    logic [IDW-1:0]   win_idx;
    logic [1:0]       win_op;
    logic             accept;
    int               idx;

    // Round-robin search: start one past the last winner and wrap, so the
    // most recently served requester has the lowest priority.
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = idx[IDW-1:0];
            end
        end
    end

    assign win_op = req_op[2*win_idx +: 2];
    // Gating with rst_n keeps req_ready at zero while reset is held even if
    // requesters are already presenting valid.
    assign accept = rst_n && (state_q == ST_IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        alu_sel_d  = alu_sel_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_sel_d = win_op;
                    alu_a_d   = req_a[WIDTH*win_idx +: WIDTH];
                    alu_b_d   = req_b[WIDTH*win_idx +: WIDTH];
                    rsp_id_d  = win_idx;
                    rr_ptr_d  = win_idx;
                    hold_d    = (win_op == 2'd0) ? CNTW'(MULT_CYCLES - 1) : '0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (hold_q == '0) begin
                    rsp_data_d = alu_result;
                    state_d    = ST_RESP;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Returning to IDLE first means no grant can coincide with
                // the response handshake.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= IDW'(NREQ - 1);
            hold_q     <= '0;
            alu_sel_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            alu_sel_q  <= alu_sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_OP_STATS_EN
    logic [63:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (accept && (stat_q[16*win_op +: 16] != 16'hFFFF)) begin
            stat_d[16*win_op +: 16] = stat_q[16*win_op +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//   Self-checking bench for alu_req_arbiter (NREQ=4, WIDTH=8, MULT_CYCLES=2).
//   The bench supplies the combinational ALU. Directed scenarios cover reset,
//   single op, multiply latency, fairness, backpressure and reset during EXEC;
//   a randomized run compares against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int NREQ        = 4;
    localparam int WIDTH       = 8;
    localparam int MULT_CYCLES = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [2*NREQ-1:0]       req_op;
    logic [WIDTH*NREQ-1:0]   req_a;
    logic [WIDTH*NREQ-1:0]   req_b;
    logic [1:0]              alu_sel;
    logic [WIDTH-1:0]        alu_a;
    logic [WIDTH-1:0]        alu_b;
    logic [WIDTH-1:0]        alu_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [WIDTH-1:0]        rsp_data;
`ifdef ALU_OP_STATS_EN
    logic [63:0]             stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: also used as the reference for expected results.
    function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int p;
        case (op)
            2'd0: begin p = int'(a) * int'(b); return p[7:0]; end
            2'd1: return a | b;
            2'd2: return a & b;
            default: return ((a != 0) && (b != 0)) ? 8'd1 : 8'd0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_sel, alu_a, alu_b);

    alu_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ALU_OP_STATS_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // Ends at posedge+1 with reset just released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'd1, 8'hAA, 8'h55);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
            end
            checks++;
            if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_rsp got valid=%b id=%0d data=%h exp 0/0/00",
                         rsp_valid, rsp_id, rsp_data);
            end
            checks++;
            if (alu_sel !== 2'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
                errors++;
                $display("FAIL reset_alu got sel=%0d a=%h b=%h exp 0/00/00", alu_sel, alu_a, alu_b);
            end
            @(posedge clk);
        end
        req_valid = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        set_req(1, 2'd1, 8'h0F, 8'hF0);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL single_grant got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (alu_sel !== 2'd1 || alu_a !== 8'h0F || alu_b !== 8'hF0) begin
            errors++;
            $display("FAIL single_alu got sel=%0d a=%h b=%h exp 1/0f/f0", alu_sel, alu_a, alu_b);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hFF) begin
            errors++;
            $display("FAIL single_rsp got valid=%b id=%0d data=%h exp 1/1/ff",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_rsp_done got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_mult();
        set_req(0, 2'd0, 8'd20, 8'd13);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL mult_grant got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL mult_early_rsp cycle=T+%0d got=%b exp=0", c, rsp_valid);
            end
            if (c == 1) tick();
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h04) begin
            errors++;
            $display("FAIL mult_rsp got valid=%b id=%0d data=%h exp 1/0/04",
                     rsp_valid, rsp_id, rsp_data);
        end
        drain();
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int k = 0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 40 && k < 5; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                checks++;
                if (req_ready !== (4'b0001 << exp_order[k])) begin
                    errors++;
                    $display("FAIL fair_grant%0d got=%b exp=%b", k, req_ready,
                             4'b0001 << exp_order[k]);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 5) begin
            errors++; $display("FAIL fair_timeout got=%0d grants exp=5", k);
        end
        drain();
    endtask

    task automatic test_backpressure();
        set_req(3, 2'd2, 8'hF0, 8'h3C);
        set_req(1, 2'd1, 8'h01, 8'h02);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        tick();
        req_valid = 4'b0010;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'h30 ||
                req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b id=%0d data=%h ready=%b exp 1/3/30/0000",
                         c, rsp_valid, rsp_id, rsp_data, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b exp 0/0010", rsp_valid, req_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid_exec();
        req_valid = '0;
        rsp_ready = 1'b1;
        do_reset();
        set_req(2, 2'd0, 8'd9, 8'd7);
        set_req(0, 2'd1, 8'h03, 8'h05);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL rme_grant2 got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL rme_exec_ready got=%b exp=0000", req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000 ||
            alu_sel !== 2'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
            errors++;
            $display("FAIL rme_async got valid=%b id=%0d ready=%b sel=%0d a=%h b=%h exp all 0",
                     rsp_valid, rsp_id, req_ready, alu_sel, alu_a, alu_b);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rme_regrant got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rme_stale_rsp got=%b exp=0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h07) begin
            errors++;
            $display("FAIL rme_rsp got valid=%b id=%0d data=%h exp 1/0/07",
                     rsp_valid, rsp_id, rsp_data);
        end
        drain();
    endtask

    // Transaction-level model: pending requests per requester, last winner,
    // one outstanding op with its predicted response cycle.
    task automatic test_random(input int ncyc);
        logic       pend[NREQ];
        logic [1:0] pop[NREQ];
        logic [7:0] pa[NREQ], pb[NREQ];
        int         last_g, exp_id, exp_cyc, acc_w, w;
        logic [7:0] exp_data;
        bit         busy, acc_prev, done_prev, exp_rv;
        logic [3:0] exp_ready;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        do_reset();
        last_g = NREQ - 1;
        busy = 1'b0; acc_prev = 1'b0; done_prev = 1'b0;
        exp_id = 0; exp_cyc = 0; exp_data = '0; acc_w = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (acc_prev) begin
                busy     = 1'b1;
                exp_id   = acc_w;
                exp_data = ref_alu(pop[acc_w], pa[acc_w], pb[acc_w]);
                exp_cyc  = cyc + ((pop[acc_w] == 2'd0) ? MULT_CYCLES : 1);
                last_g   = acc_w;
                pend[acc_w] = 1'b0;
            end
            if (done_prev) busy = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pop[i]  = 2'($urandom_range(0, 3));
                    pa[i]   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                    pb[i]   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                end
                req_valid[i] = pend[i];
                set_req(i, pop[i], pa[i], pb[i]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = busy && (cyc >= exp_cyc);
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rsp_id !== 2'(exp_id) || rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL rand_rsp cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                             cyc, rsp_id, rsp_data, exp_id, exp_data);
                end
            end
            w = -1;
            if (!busy) begin
                for (int off = 1; off <= NREQ; off++) begin
                    if (w < 0 && pend[(last_g + off) % NREQ]) w = (last_g + off) % NREQ;
                end
            end
            exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            end
            acc_prev  = (w >= 0);
            acc_w     = (w >= 0) ? w : 0;
            done_prev = exp_rv && rsp_ready;
            tick();
        end
        drain();
    endtask

`ifdef ALU_OP_STATS_EN
    task automatic test_stats();
        logic [7:0] av[3] = '{8'd5, 8'd5, 8'd0};
        logic [7:0] bv[3] = '{8'd0, 8'd1, 8'd0};
        logic [7:0] ev[3] = '{8'd0, 8'd1, 8'd0};
        req_valid = '0;
        rsp_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            int c = 0;
            set_req(0, 2'd3, av[n], bv[n]);
            req_valid = 4'b0001;
            #1;
            tick();
            req_valid = '0;
            while (rsp_valid !== 1'b1 && c < 10) begin tick(); c++; end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ev[n]) begin
                errors++;
                $display("FAIL stats_op%0d got valid=%b data=%h exp 1/%h", n, rsp_valid, rsp_data, ev[n]);
            end
            tick();
        end
        checks++;
        if (stat_cnt !== 64'h0003_0000_0000_0000) begin
            errors++; $display("FAIL stats_cnt got=%h exp=0003000000000000", stat_cnt);
        end
        drain();
    endtask
`endif

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_mult();
        test_fairness();
        test_backpressure();
        test_reset_mid_exec();
        test_random(3000);
`ifdef ALU_OP_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
